// File: rtl/fir_pkg.sv
// Shared types and width helpers for the sequential FIR MAC filter.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } fir_state_t;

  function automatic int unsigned fir_acc_w(input int unsigned data_w,
                                            input int unsigned coef_w,
                                            input int unsigned ntaps);
    return data_w + coef_w + $clog2(ntaps);
  endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Round-half-up arithmetic shift of the accumulator, then clamp to the signed output range.
module fir_round_sat #(
  parameter int unsigned ACC_W     = 35,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned OUT_SHIFT = 15
) (
  input  logic signed [ACC_W-1:0]  acc,
  output logic signed [DATA_W-1:0] result
);

  localparam logic signed [ACC_W:0] RND =
    $signed({{ACC_W{1'b0}}, 1'b1} << (OUT_SHIFT - 1));
  localparam logic signed [ACC_W:0] MAX_EXT =
    $signed({{(ACC_W + 2 - DATA_W){1'b0}}, {(DATA_W - 1){1'b1}}});
  localparam logic signed [ACC_W:0] MIN_EXT =
    $signed({{(ACC_W + 2 - DATA_W){1'b1}}, {(DATA_W - 1){1'b0}}});

  logic signed [ACC_W:0] sum;
  logic signed [ACC_W:0] shifted;

  // One guard bit so the rounding constant can never wrap the sum.
  assign sum     = {acc[ACC_W-1], acc} + RND;
  assign shifted = sum >>> OUT_SHIFT;

  always_comb begin
    result = shifted[DATA_W-1:0];
    if (shifted > MAX_EXT)
      result = MAX_EXT[DATA_W-1:0];
    else if (shifted < MIN_EXT)
      result = MIN_EXT[DATA_W-1:0];
  end

endmodule

// File: rtl/fir_mac_filter.sv
// Sequential FIR: one multiply-accumulate per clock over an NTAPS delay line,
// with loadable coefficients and valid/ready handshakes on input and output.
module fir_mac_filter
  import fir_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned COEF_W    = 16,
  parameter int unsigned NTAPS     = 8,
  parameter int unsigned OUT_SHIFT = 15
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       coef_we,
  input  logic [$clog2(NTAPS)-1:0]   coef_addr,
  input  logic signed [COEF_W-1:0]   coef_data,
  output logic                       coef_drop,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [DATA_W-1:0]   in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [DATA_W-1:0]   out_data
);

  localparam int unsigned ACC_W  = fir_acc_w(DATA_W, COEF_W, NTAPS);
  localparam int unsigned AW     = $clog2(NTAPS);
  localparam int unsigned PROD_W = DATA_W + COEF_W;
  localparam logic [AW-1:0] LAST = AW'(NTAPS - 1);

  fir_state_t state, state_nxt;

  logic signed [DATA_W-1:0] dline [NTAPS];
  logic signed [COEF_W-1:0] coef  [NTAPS];
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [PROD_W-1:0] prod;
  logic signed [DATA_W-1:0] rs_result;
  logic [AW-1:0]            k;
  logic                     accept;
  logic                     coef_ok;

  assign in_ready  = (state == IDLE);
  assign accept    = in_ready && in_valid;
  assign coef_ok   = coef_we && (state == IDLE);
  assign coef_drop = coef_we && (state != IDLE);

  assign prod    = PROD_W'(coef[k]) * PROD_W'(dline[k]);
  assign acc_sum = acc + {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};

  // The last tap's sum is rounded straight from acc_sum so the result
  // lands in out_data on the same edge the FSM enters OUT.
  fir_round_sat #(
    .ACC_W    (ACC_W),
    .DATA_W   (DATA_W),
    .OUT_SHIFT(OUT_SHIFT)
  ) u_round_sat (
    .acc   (acc_sum),
    .result(rs_result)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)   state_nxt = MAC;
      MAC:     if (k == LAST)  state_nxt = OUT;
      OUT:     if (out_ready)  state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      out_valid <= (state_nxt == OUT);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NTAPS; i++) begin
        dline[i] <= '0;
        coef[i]  <= '0;
      end
      acc      <= '0;
      k        <= '0;
      out_data <= '0;
    end else begin
      if (coef_ok)
        coef[coef_addr] <= coef_data;
      if (accept) begin
        dline[0] <= in_data;
        for (int unsigned i = 1; i < NTAPS; i++)
          dline[i] <= dline[i-1];
        acc <= '0;
        k   <= '0;
      end else if (state == MAC) begin
        acc <= acc_sum;
        k   <= k + 1'b1;
        if (k == LAST)
          out_data <= rs_result;
      end
    end
  end

endmodule

// File: tb/tb_fir_mac_filter.sv
// Self-checking bench for fir_mac_filter: vector tables, corner-case sequences and
// randomized traffic against an arithmetic reference model of the filter.
module tb_fir_mac_filter;

  typedef struct {
    logic signed [15:0] din;
    logic signed [15:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset;

  // Default-parameter instance
  logic               coef_we;
  logic [2:0]         coef_addr;
  logic signed [15:0] coef_data;
  logic               coef_drop;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_data;

  // Small instance: NTAPS=2, 8-bit data/coefs, shift 7
  logic               s_coef_we;
  logic [0:0]         s_coef_addr;
  logic signed [7:0]  s_coef_data;
  logic               s_coef_drop;
  logic               s_in_valid;
  logic               s_in_ready;
  logic signed [7:0]  s_in_data;
  logic               s_out_valid;
  logic               s_out_ready;
  logic signed [7:0]  s_out_data;

  int tests;
  int fails;
  int exp_next;
  int coef_m [8];
  int hist   [8];

  always #5 clk = ~clk;

  fir_mac_filter dut (
    .clk      (clk),
    .reset    (reset),
    .coef_we  (coef_we),
    .coef_addr(coef_addr),
    .coef_data(coef_data),
    .coef_drop(coef_drop),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  fir_mac_filter #(
    .DATA_W   (8),
    .COEF_W   (8),
    .NTAPS    (2),
    .OUT_SHIFT(7)
  ) dut_small (
    .clk      (clk),
    .reset    (reset),
    .coef_we  (s_coef_we),
    .coef_addr(s_coef_addr),
    .coef_data(s_coef_data),
    .coef_drop(s_coef_drop),
    .in_valid (s_in_valid),
    .in_ready (s_in_ready),
    .in_data  (s_in_data),
    .out_valid(s_out_valid),
    .out_ready(s_out_ready),
    .out_data (s_out_data)
  );

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin
      coef_m[i] = 0;
      hist[i]   = 0;
    end
  endfunction

  // Reference: y = clamp(round(sum(c[i]*x[n-i]) / 2^15))
  function automatic int model_push(input int x);
    longint s;
    for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = x;
    s = 0;
    for (int i = 0; i < 8; i++) s += longint'(coef_m[i]) * longint'(hist[i]);
    s = (s + 64'sd16384) >>> 15;
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    return int'(s);
  endfunction

  task automatic write_coef(input int a, input int v);
    coef_we   = 1'b1;
    coef_addr = 3'(a);
    coef_data = 16'(v);
    coef_m[a] = v;
    #1;
    check("coef_drop_idle", coef_drop, 0);
    @(posedge clk); #1;
    coef_we = 1'b0;
  endtask

  task automatic send(input int x);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = 16'(x);
    #1;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) check("send_timeout", in_ready, 1);
    exp_next = model_push(x);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic collect(input int stall, input int busy_at, input int exp,
                         input string name, output int y);
    int lat;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (lat == busy_at) begin
        coef_we   = 1'b1;
        coef_addr = 3'd0;
        coef_data = 16'sd0;
        #1;
        check("coef_drop_busy", coef_drop, 1);
        @(posedge clk); #1;
        lat++;
        coef_we = 1'b0;
        #1;
        check("coef_drop_one_cycle", coef_drop, 0);
      end
    end
    check({name, "_latency"}, lat, 8);
    check({name, "_data"}, out_data, exp);
    y = out_data;
    if (stall > 0) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 16'sd0;
      for (int i = 0; i < stall; i++) begin
        @(posedge clk); #1;
        check("bp_out_valid", out_valid, 1);
        check("bp_out_data", out_data, y);
        check("bp_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check({name, "_valid_drop"}, out_valid, 0);
    check({name, "_in_ready"}, in_ready, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t imp [4];
    vec_t small_vec [2];
    int y;
    int lat;
    int guard;

    tests = 0;
    fails = 0;
    model_reset();
    reset     = 1'b0;
    coef_we   = 1'b1;
    coef_addr = '0;
    coef_data = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    s_coef_we   = 1'b0;
    s_coef_addr = '0;
    s_coef_data = '0;
    s_in_valid  = 1'b0;
    s_in_data   = '0;
    s_out_ready = 1'b1;

    imp[0] = '{din: 16'sd1000, exp: 16'sd500};
    imp[1] = '{din: 16'sd0,    exp: 16'sd250};
    imp[2] = '{din: 16'sd0,    exp: 16'sd0};
    imp[3] = '{din: 16'sd0,    exp: 16'sd0};
    small_vec[0] = '{din: 16'sd100, exp: 16'sd50};
    small_vec[1] = '{din: 16'sd100, exp: 16'sd100};

    // Reset state
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_coef_drop", coef_drop, 0);
    check("rst_out_data", out_data, 0);
    coef_we = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("rel_in_ready", in_ready, 1);

    // Impulse response
    write_coef(0, 16384);
    write_coef(1, 8192);
    for (int i = 0; i < 4; i++) begin
      send(imp[i].din);
      collect(0, -1, imp[i].exp, "impulse", y);
    end

    // Positive and negative saturation
    for (int i = 0; i < 8; i++) write_coef(i, 32767);
    for (int i = 0; i < 8; i++) begin
      send(32767);
      collect(0, -1, exp_next, "sat_pos", y);
    end
    check("sat_pos_full", y, 32767);
    for (int i = 0; i < 8; i++) begin
      send(-32768);
      collect(0, -1, exp_next, "sat_neg", y);
    end
    check("sat_neg_full", y, -32768);

    // Backpressure with a pending sample during OUT
    write_coef(0, 16384);
    write_coef(1, 8192);
    for (int i = 2; i < 8; i++) write_coef(i, 0);
    send(1000);
    collect(5, -1, exp_next, "bp", y);
    send(0);
    collect(0, -1, exp_next, "bp_next", y);

    // Coefficient write while busy is dropped
    send(1000);
    collect(0, 2, exp_next, "busy", y);
    check("busy_first_500", y, 500);
    send(0);
    collect(0, -1, 250, "busy_next", y);

    // Reset in the middle of MAC
    send(1000);
    repeat (3) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_data", out_data, 0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("mid_rel_in_ready", in_ready, 1);
    check("mid_rel_coef_drop", coef_drop, 0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("mid_rel_no_valid", out_valid, 0);
    end
    send(1000);
    collect(0, -1, 0, "post_reset", y);

    // Coefficient write in the same cycle as sample acceptance
    coef_we   = 1'b1;
    coef_addr = 3'd0;
    coef_data = 16'sd16384;
    coef_m[0] = 16384;
    send(1000);
    coef_we = 1'b0;
    collect(0, -1, exp_next, "same_cycle_wr", y);

    // Randomized coefficients, samples and stalls
    for (int i = 0; i < 8; i++) write_coef(i, int'($urandom_range(0, 65535)) - 32768);
    for (int n = 0; n < 30; n++) begin
      send(int'($urandom_range(0, 65535)) - 32768);
      collect(int'($urandom_range(0, 2)), -1, exp_next, "random", y);
    end

    // Small configuration
    s_coef_we   = 1'b1;
    s_coef_addr = 1'b0;
    s_coef_data = 8'sd64;
    @(posedge clk); #1;
    s_coef_addr = 1'b1;
    @(posedge clk); #1;
    s_coef_we = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_in_valid = 1'b1;
      s_in_data  = small_vec[i].din[7:0];
      guard = 0;
      #1;
      while (!s_in_ready && guard < 50) begin
        @(posedge clk); #1;
        guard++;
      end
      @(posedge clk); #1;
      s_in_valid = 1'b0;
      lat = 0;
      while (!s_out_valid && lat < 50) begin
        @(posedge clk); #1;
        lat++;
      end
      check("small_latency", lat, 2);
      check("small_data", s_out_data, small_vec[i].exp);
      @(posedge clk); #1;
      check("small_valid_drop", s_out_valid, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fir_mac_filter.md
# fir_mac_filter

Parametrised, sequential FIR filter for the FPGA datapath, the successor to the combinational 4-bit tap/data math block. It accepts signed samples over a valid/ready handshake and holds them in an NTAPS-deep delay line. One multiply-accumulate runs per clock over runtime-loadable coefficients. The rounded, saturated result is returned over a second valid/ready handshake.

## Interface
- DATA_W, 16, sample and output width, signed two's complement.
- COEF_W, 16, coefficient width, signed, Q(COEF_W-1).
- NTAPS, 8, number of taps. Must be ≥2.
- OUT_SHIFT, 15, arithmetic right shift applied to the accumulator before saturation. Must be ≥1.
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  $clog2(NTAPS)  coefficient index.
- coef_data  in  COEF_W  coefficient value, signed.
- coef_drop  out  1  one-cycle pulse: the write was rejected because the filter was busy.
- in_valid  in  1  sample present.
- in_ready  out  1  filter can accept a sample.
- in_data  in  DATA_W  sample, signed.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_data  out  DATA_W  filtered result, signed.

## Operation
- Internal widths: accumulator ACC_W = DATA_W + COEF_W + $clog2(NTAPS), signed. Each product is sign-extended to ACC_W before it is added.
- States:
  - IDLE: in_ready=1.
  - MAC: tap index k counts 0..NTAPS-1.
  - OUT: out_valid=1.
- IDLE → MAC on in_valid && in_ready.
  - The delay line shifts: d[0] ← in_data, d[i] ← d[i-1].
  - acc ← 0 and k ← 0.
- MAC: each cycle acc ← acc + coef[k]*d[k] and k ← k+1.
  - On the cycle with k = NTAPS-1, the final sum goes through round/saturate: add 1<<(OUT_SHIFT-1), then arithmetic shift right by OUT_SHIFT.
  - Saturation clamps to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - The result is registered into out_data and the state moves to OUT.
- OUT → IDLE on out_ready. out_data holds its last value in IDLE.
- Coefficient writes:
  - Accepted only in IDLE; coef[coef_addr] updates at the clock edge.
  - When coef_we=1 outside IDLE, the write is discarded and coef_drop pulses high for that cycle.
  - A write in the same IDLE cycle as a sample acceptance is applied. That sample's MAC sees the new coefficient.
- Reset, at any time including mid-MAC or in OUT:
  - state ← IDLE; delay line, coefficients, acc and out_data ← 0.
  - out_valid=0, coef_drop=0, in_ready=1 as soon as reset deasserts.
  - Any partial result is lost.

## Timing
- Sample accepted at edge T. out_valid rises after edge T+NTAPS, i.e. NTAPS cycles of MAC.
- Throughput: at most one sample per NTAPS+2 cycles with out_ready held high.
- in_ready is low in MAC and OUT.
- out_valid and out_data stay stable while out_ready=0. There is no limit on how long the consumer stalls.
- The result transfers at the first edge with out_valid && out_ready. out_valid is low the following cycle.
- All outputs are registered except in_ready and coef_drop, which decode combinationally from the state and coef_we.

## Structure
- Package fir_pkg:
  - State enum typedef: IDLE, MAC, OUT.
  - Localparam helper for ACC_W.
- Sub-module fir_round_sat: combinational, parametrised by ACC_W, DATA_W and OUT_SHIFT. Performs the rounding shift and saturation so it can be unit-tested in isolation.
- Top level holds the FSM, delay line, coefficient register file and MAC.

## Test plan
Bench runs at default parameters unless stated.
- Impulse: load coef {16384, 8192, 0, ...}, then feed 1000, 0, 0, 0 → outputs 500, 250, 0, 0; each out_valid arrives exactly 8 cycles after acceptance.
- Positive saturation: all coefs 32767, eight samples of 32767 → every output after the pipeline fills equals 32767. Negative case: samples of -32768 → outputs clamp to -32768.
- Backpressure: hold out_ready=0 for 5 cycles during OUT → out_data constant and in_ready=0 throughout. A pending in_valid is accepted only once the filter has returned to IDLE.
- Busy write: assert coef_we with coef_addr=0, coef_data=0 during MAC → coef_drop pulses for one cycle and the next impulse response still starts at 500.
- Reset mid-MAC: assert reset at k=3 → out_valid stays 0, in_ready=1 after release. The next impulse of 1000 produces 0, because all coefficients were cleared.
- NTAPS=2, DATA_W=8, COEF_W=8, OUT_SHIFT=7: coefs {64, 64}, inputs 100, 100 → outputs 50, 100.
